// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
// Contents: opcode constants, ALUOp codes (these must match the values
// decoded by the ALU control block), ALUSrcB / PCSource select encodings,
// the 4-bit state encoding, and the packed control-word type.
package multicycle_control_pkg;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encoding (codes 12..15 are unreachable)
    localparam logic [3:0] ST_FETCH        = 4'd0;
    localparam logic [3:0] ST_DECODE       = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR     = 4'd2;
    localparam logic [3:0] ST_MEM_READ     = 4'd3;
    localparam logic [3:0] ST_MEM_WB       = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE    = 4'd5;
    localparam logic [3:0] ST_EXECUTE      = 4'd6;
    localparam logic [3:0] ST_R_COMPLETE   = 4'd7;
    localparam logic [3:0] ST_BRANCH       = 4'd8;
    localparam logic [3:0] ST_JUMP         = 4'd9;
    localparam logic [3:0] ST_IMM_EXEC     = 4'd10;
    localparam logic [3:0] ST_IMM_COMPLETE = 4'd11;

    // Full set of datapath control signals produced each cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 17'b0;

    // True for the opcodes this controller knows how to sequence
    function automatic logic is_legal_opcode(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: is_legal_opcode = 1'b1;
            default:                                         is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   Opcode[5:0]      - IR opcode field, valid from DECODE onward
//   MemReady         - memory access completes this cycle
//   PCWrite .. PCSource - datapath enables and mux selects (Moore, except
//                      PCWrite/IRWrite in FETCH which follow MemReady)
//   IllegalOp        - sticky undefined-opcode flag
//   InstrCount       - retired-instruction counter, wraps
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Opcode,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUOp,
    output logic [1:0]             PCSource,
    output logic                   IllegalOp,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    logic [3:0]             state_r;
    logic [3:0]             state_next_s;
    logic                   retire_s;
    logic                   illegal_s;
    logic                   illegal_r;
    logic [COUNT_WIDTH-1:0] count_r;
    ctrl_t                  ctrl_s;
    ctrl_t                  ctrl_out_s;

    // Next-state logic; also flags retirement and illegal-opcode events
    always_comb begin
        state_next_s = ST_FETCH;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (MemReady) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!is_legal_opcode(Opcode)) begin
                    state_next_s = ST_FETCH;
                    illegal_s    = 1'b1;
                end else begin
                    case (Opcode)
                        OP_LW, OP_SW:    state_next_s = ST_MEM_ADDR;
                        OP_R:            state_next_s = ST_EXECUTE;
                        OP_BEQ:          state_next_s = ST_BRANCH;
                        OP_J:            state_next_s = ST_JUMP;
                        OP_ADDI, OP_ORI: state_next_s = ST_IMM_EXEC;
                        default:         state_next_s = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_ADDR: begin
                // IR is frozen, so Opcode is still LW or SW here
                if (Opcode == OP_LW) begin
                    state_next_s = ST_MEM_READ;
                end else if (Opcode == OP_SW) begin
                    state_next_s = ST_MEM_WRITE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM_READ: begin
                if (MemReady) begin
                    state_next_s = ST_MEM_WB;
                end else begin
                    state_next_s = ST_MEM_READ;
                end
            end
            ST_MEM_WB: begin
                state_next_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_MEM_WRITE: begin
                if (MemReady) begin
                    state_next_s = ST_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = ST_MEM_WRITE;
                end
            end
            ST_EXECUTE:      state_next_s = ST_R_COMPLETE;
            ST_R_COMPLETE: begin
                state_next_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_BRANCH, ST_JUMP: begin
                state_next_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_IMM_EXEC:     state_next_s = ST_IMM_COMPLETE;
            ST_IMM_COMPLETE: begin
                state_next_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            default:         state_next_s = ST_FETCH;
        endcase
    end

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
            count_r   <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (illegal_s) begin
                illegal_r <= 1'b1;
            end
            if (retire_s) begin
                count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Moore output decode from the state register
    always_comb begin
        ctrl_s = CTRL_NONE;
        case (state_r)
            ST_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.iord      = 1'b0;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_source = PCSRC_ALU;
                // PC+4 and the IR only load once the fetch data is back
                ctrl_s.ir_write  = MemReady;
                ctrl_s.pc_write  = MemReady;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_IMM_SH2;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            ST_R_COMPLETE: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a     = 1'b1;
                ctrl_s.alu_src_b     = SRCB_B;
                ctrl_s.alu_op        = ALUOP_SUB;
                ctrl_s.pc_write_cond = 1'b1;
                ctrl_s.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_source = PCSRC_JUMP;
            end
            ST_IMM_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                if (Opcode == OP_ORI) begin
                    ctrl_s.alu_op = ALUOP_OR;
                end else begin
                    ctrl_s.alu_op = ALUOP_ADD;
                end
            end
            ST_IMM_COMPLETE: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b0;
            end
            default: ctrl_s = CTRL_NONE;
        endcase
    end

    // Hold every control line low while reset is asserted
    always_comb begin
        if (reset) begin
            ctrl_out_s = CTRL_NONE;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign PCWrite     = ctrl_out_s.pc_write;
    assign PCWriteCond = ctrl_out_s.pc_write_cond;
    assign IorD        = ctrl_out_s.iord;
    assign MemRead     = ctrl_out_s.mem_read;
    assign MemWrite    = ctrl_out_s.mem_write;
    assign IRWrite     = ctrl_out_s.ir_write;
    assign MemtoReg    = ctrl_out_s.mem_to_reg;
    assign RegDst      = ctrl_out_s.reg_dst;
    assign RegWrite    = ctrl_out_s.reg_write;
    assign ALUSrcA     = ctrl_out_s.alu_src_a;
    assign ALUSrcB     = ctrl_out_s.alu_src_b;
    assign ALUOp       = ctrl_out_s.alu_op;
    assign PCSource    = ctrl_out_s.pc_source;
    assign IllegalOp   = illegal_r;
    assign InstrCount  = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Inputs change just after the
// falling edge and outputs are sampled 1ns later, well away from the
// rising edge. The counter is built 3 bits wide so that wrap is reachable.
module tb_multicycle_control;

    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic [5:0]    Opcode;
    logic          MemReady;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [2:0]    ALUOp;
    logic [1:0]    PCSource;
    logic          IllegalOp;
    logic [CW-1:0] InstrCount;

    int checks;
    int failures;

    // Opcodes
    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J_OP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] BAD  = 6'b111111;

    // Expected control words, bit order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0]
    localparam logic [16:0] E_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [16:0] E_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_100_00;
    localparam logic [16:0] E_FETCH_W   = 17'b0_0_0_1_0_0_0_0_0_0_01_100_00;
    localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_100_00;
    localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_100_00;
    localparam logic [16:0] E_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_000_00;
    localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_000_00;
    localparam logic [16:0] E_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_000_00;
    localparam logic [16:0] E_EXECUTE   = 17'b0_0_0_0_0_0_0_0_0_1_00_111_00;
    localparam logic [16:0] E_R_COMP    = 17'b0_0_0_0_0_0_0_1_1_0_00_000_00;
    localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_001_01;
    localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_000_10;
    localparam logic [16:0] E_IMM_ADD   = 17'b0_0_0_0_0_0_0_0_0_1_10_100_00;
    localparam logic [16:0] E_IMM_OR    = 17'b0_0_0_0_0_0_0_0_0_1_10_101_00;
    localparam logic [16:0] E_IMM_COMP  = 17'b0_0_0_0_0_0_0_0_1_0_00_000_00;

    logic [16:0] ctrl_vec;
    assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .IllegalOp   (IllegalOp),
        .InstrCount  (InstrCount)
    );

    // Free-running clock, first rising edge at 5ns
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check the control word
    task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [16:0] exp, input string tag);
        @(negedge clk);
        reset    = rst;
        Opcode   = op;
        MemReady = mr;
        #1;
        check_eq(tag, {15'b0, ctrl_vec}, {15'b0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        Opcode   = BAD;
        MemReady = 1'b1;

        // Reset held two cycles with a garbage opcode
        cyc(1'b1, BAD, 1'b1, E_ZERO, "rst_c0");
        cyc(1'b1, BAD, 1'b1, E_ZERO, "rst_c1");
        check_eq("rst_cnt", {29'b0, InstrCount}, 32'd0);
        check_eq("rst_ill", {31'b0, IllegalOp}, 32'd0);

        // R-type, no wait states
        cyc(1'b0, R_OP, 1'b1, E_FETCH_RDY, "r_fetch");
        cyc(1'b0, R_OP, 1'b1, E_DECODE,    "r_decode");
        cyc(1'b0, R_OP, 1'b1, E_EXECUTE,   "r_exec");
        cyc(1'b0, R_OP, 1'b1, E_R_COMP,    "r_comp");
        check_eq("r_cnt_before", {29'b0, InstrCount}, 32'd0);

        // LW with three wait cycles in MEM_READ (8 cycles total)
        cyc(1'b0, LW, 1'b1, E_FETCH_RDY, "lw_fetch");
        check_eq("r_cnt_after", {29'b0, InstrCount}, 32'd1);
        cyc(1'b0, LW, 1'b1, E_DECODE,    "lw_decode");
        cyc(1'b0, LW, 1'b1, E_MEM_ADDR,  "lw_addr");
        cyc(1'b0, LW, 1'b0, E_MEM_READ,  "lw_rd_w0");
        cyc(1'b0, LW, 1'b0, E_MEM_READ,  "lw_rd_w1");
        cyc(1'b0, LW, 1'b0, E_MEM_READ,  "lw_rd_w2");
        cyc(1'b0, LW, 1'b1, E_MEM_READ,  "lw_rd_done");
        cyc(1'b0, LW, 1'b0, E_MEM_WB,    "lw_wb");

        // SW with a fetch stall, no memory wait
        cyc(1'b0, SW, 1'b0, E_FETCH_W,   "sw_fetch_w");
        check_eq("lw_cnt", {29'b0, InstrCount}, 32'd2);
        cyc(1'b0, SW, 1'b1, E_FETCH_RDY, "sw_fetch");
        cyc(1'b0, SW, 1'b1, E_DECODE,    "sw_decode");
        cyc(1'b0, SW, 1'b1, E_MEM_ADDR,  "sw_addr");
        cyc(1'b0, SW, 1'b1, E_MEM_WRITE, "sw_write");

        // BEQ (MemReady low in DECODE must be ignored) then J
        cyc(1'b0, BEQ, 1'b1, E_FETCH_RDY, "beq_fetch");
        check_eq("sw_cnt", {29'b0, InstrCount}, 32'd3);
        cyc(1'b0, BEQ, 1'b0, E_DECODE,    "beq_decode");
        cyc(1'b0, BEQ, 1'b0, E_BRANCH,    "beq_branch");
        cyc(1'b0, J_OP, 1'b1, E_FETCH_RDY, "j_fetch");
        cyc(1'b0, J_OP, 1'b1, E_DECODE,    "j_decode");
        cyc(1'b0, J_OP, 1'b1, E_JUMP,      "j_jump");

        // ADDI then ORI
        cyc(1'b0, ADDI, 1'b1, E_FETCH_RDY, "addi_fetch");
        check_eq("beq_j_cnt", {29'b0, InstrCount}, 32'd5);
        cyc(1'b0, ADDI, 1'b1, E_DECODE,    "addi_decode");
        cyc(1'b0, ADDI, 1'b1, E_IMM_ADD,   "addi_exec");
        cyc(1'b0, ADDI, 1'b1, E_IMM_COMP,  "addi_comp");
        cyc(1'b0, ORI,  1'b1, E_FETCH_RDY, "ori_fetch");
        cyc(1'b0, ORI,  1'b1, E_DECODE,    "ori_decode");
        cyc(1'b0, ORI,  1'b1, E_IMM_OR,    "ori_exec");
        cyc(1'b0, ORI,  1'b1, E_IMM_COMP,  "ori_comp");

        // Illegal opcode: back to FETCH, flag set, count unchanged
        cyc(1'b0, BAD, 1'b1, E_FETCH_RDY, "bad_fetch");
        check_eq("imm_cnt", {29'b0, InstrCount}, 32'd7);
        check_eq("ill_pre", {31'b0, IllegalOp}, 32'd0);
        cyc(1'b0, BAD, 1'b1, E_DECODE,    "bad_decode");
        cyc(1'b0, J_OP, 1'b1, E_FETCH_RDY, "bad_refetch");
        check_eq("ill_set", {31'b0, IllegalOp}, 32'd1);
        check_eq("ill_cnt", {29'b0, InstrCount}, 32'd7);

        // J retires the 8th instruction: 3-bit counter wraps to 0
        cyc(1'b0, J_OP, 1'b1, E_DECODE,    "j2_decode");
        cyc(1'b0, J_OP, 1'b1, E_JUMP,      "j2_jump");
        cyc(1'b0, SW, 1'b0, E_FETCH_W,     "sw2_fetch_w");
        check_eq("wrap_cnt", {29'b0, InstrCount}, 32'd0);
        check_eq("ill_sticky", {31'b0, IllegalOp}, 32'd1);

        // SW stalled in MEM_WRITE, then reset aborts it
        cyc(1'b0, SW, 1'b1, E_FETCH_RDY, "sw2_fetch");
        cyc(1'b0, SW, 1'b1, E_DECODE,    "sw2_decode");
        cyc(1'b0, SW, 1'b0, E_MEM_ADDR,  "sw2_addr");
        cyc(1'b0, SW, 1'b0, E_MEM_WRITE, "sw2_wr_w0");
        cyc(1'b0, SW, 1'b0, E_MEM_WRITE, "sw2_wr_w1");
        cyc(1'b1, SW, 1'b1, E_ZERO,      "sw2_rst");
        cyc(1'b0, SW, 1'b0, E_FETCH_W,   "post_rst_fetch");
        check_eq("post_rst_ill", {31'b0, IllegalOp}, 32'd0);
        check_eq("post_rst_cnt", {29'b0, InstrCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Decodes the 6-bit opcode held in the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back.
- Drives every datapath enable and mux select, plus the 3-bit ALUOp consumed by the downstream ALU control decoder.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Opcode  input  6  instruction[31:26] from the IR; valid from DECODE onward.
- MemReady  input  1  memory access completes in the current cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU Zero (branch).
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-back data: 0=ALUOut, 1=MDR.
- RegDst  output  1  destination: 0=rt, 1=rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0=PC, 1=A.
- ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- ALUOp  output  3  100=add, 101=or, 111=use function field, 001=subtract.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- IllegalOp  output  1  sticky flag, set on an undefined opcode.
- InstrCount  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- Single clk. Reset is synchronous and active-high. On a reset edge: state=FETCH, InstrCount=0, IllegalOp=0.
- While reset is high, all control outputs are forced to 0.
- Control outputs are Moore (decoded from the state register). Exception: PCWrite and IRWrite in FETCH are gated by MemReady.
- Any output not listed for a state is 0.
- Opcodes:
  - R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, ORI=001101.
- States (4-bit) and their outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (precompute branch target).
    - LW/SW -> MEM_ADDR; R -> EXECUTE; BEQ -> BRANCH; J -> JUMP; ADDI/ORI -> IMM_EXEC.
    - Any other opcode -> FETCH, sets IllegalOp, InstrCount unchanged.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. LW -> MEM_READ, SW -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. Holds until MemReady, then MEM_WB.
  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> R_COMPLETE.
  - R_COMPLETE: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - IMM_EXEC: ALUSrcA=1, ALUSrcB=10; ALUOp=100 for ADDI, 101 for ORI -> IMM_COMPLETE.
  - IMM_COMPLETE: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Instruction latency in cycles, with zero wait states: LW 5, SW 4, R 4, ADDI/ORI 4, BEQ 3, J 3. Each wait cycle adds 1.
- InstrCount increments by 1 on every transition into FETCH from a completion state: MEM_WB, MEM_WRITE, R_COMPLETE, BRANCH, JUMP, IMM_COMPLETE.
  - It wraps modulo 2^COUNT_WIDTH.
  - The illegal-opcode exit from DECODE does not increment it.
- Opcode is sampled combinationally in DECODE, MEM_ADDR and IMM_EXEC. The IR holds it stable because IRWrite=0 outside FETCH.
- Reset asserted mid-instruction (including during a MemReady stall) aborts the instruction. The next state is FETCH and the count is not incremented.
- MemReady is ignored in all states other than FETCH, MEM_READ and MEM_WRITE.
- Unreachable state encodings go to FETCH with all outputs 0.

Decomposition:
- Shared package: opcode constants, ALUOp codes (ADD, OR, FUNCT, SUB), ALUSrcB and PCSource select encodings, state encoding.
- The ALUOp codes must match the decoder values in the ALU control block.
- No sub-module: one state register, next-state logic, output decode, counter.

Test Plan:
- Reset high for 2 cycles with garbage Opcode -> all outputs 0, InstrCount=0. After release: FETCH with MemRead=1, ALUSrcB=01, ALUOp=100.
- R-type with MemReady=1 in FETCH -> states FETCH, DECODE, EXECUTE (ALUOp=111), R_COMPLETE (RegWrite=1, RegDst=1). InstrCount goes 0->1 on re-entering FETCH.
- LW with MemReady held low for 3 cycles in MEM_READ -> MemRead=1, IorD=1 held for 4 cycles. Then MEM_WB with MemtoReg=1, RegWrite=1. Total 8 cycles.
- BEQ then J -> BRANCH drives ALUOp=001, PCWriteCond=1, PCSource=01. JUMP drives PCWrite=1, PCSource=10. InstrCount +2.
- ADDI then ORI -> IMM_EXEC drives ALUOp=100 then 101 respectively. IMM_COMPLETE drives RegDst=0, RegWrite=1.
- Opcode 111111 in DECODE -> returns to FETCH, IllegalOp=1 and stays 1, InstrCount unchanged. Reset mid-SW stall -> FETCH, IllegalOp=0.
